// File: rtl/fan_in_reduce_sched.sv
// Purpose: reduces QUANTITY words with AND/OR on one shared 3-input unit, two new words per step.
// Latency: accept in cycle C gives out_valid in C+1+ceil((QUANTITY-1)/2). Optional macro FAN_IN_SCHED_FLUSH_EN enables job abort.
// Backpressure: a single job is in flight. in_ready is low until the result is taken with out_ready.
module fan_in_reduce_sched #(
    parameter int WIDTH    = 32,
    parameter int QUANTITY = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_op,
    input  logic [WIDTH*QUANTITY-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      busy,
    input  logic                      flush
);
    // idx may step past the last word by up to two, so size it for QUANTITY+2
    localparam int IW = $clog2(QUANTITY + 2);
    localparam logic [IW:0] QLAST = (IW+1)'(QUANTITY);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state;
    logic [WIDTH*QUANTITY-1:0] data_q;
    logic [WIDTH-1:0]          acc;
    logic [IW-1:0]             idx;
    logic                      op_q;

    logic [WIDTH-1:0]          ident;
    logic [WIDTH-1:0]          w_a;
    logic [WIDTH-1:0]          w_b;
    logic [WIDTH-1:0]          step;
    logic [IW:0]               idx_nxt2;

    assign ident    = op_q ? '0 : '1;
    assign idx_nxt2 = {1'b0, idx} + (IW+1)'(2);

    // Words beyond the end of the job read as the identity of the current op
    always_comb begin
        w_a = ident;
        w_b = ident;
        for (int i = 0; i < QUANTITY; i++) begin
            if (idx == IW'(i))
                w_a = data_q[i*WIDTH +: WIDTH];
            if (idx + IW'(1) == IW'(i))
                w_b = data_q[i*WIDTH +: WIDTH];
        end
    end

    assign step = op_q ? (acc | w_a | w_b) : (acc & w_a & w_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            idx    <= '0;
            op_q   <= 1'b0;
            data_q <= '0;
`ifdef FAN_IN_SCHED_FLUSH_EN
        end else if (flush && state != IDLE) begin
            state <= IDLE;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        op_q   <= in_op;
                        acc    <= in_data[WIDTH-1:0];
                        idx    <= IW'(1);
                        state  <= (QUANTITY > 1) ? RUN : DONE;
                    end
                end
                RUN: begin
                    acc <= step;
                    idx <= idx_nxt2[IW-1:0];
                    if (idx_nxt2 >= QLAST)
                        state <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef FAN_IN_SCHED_FLUSH_EN
    logic unused_flush;
    assign unused_flush = flush;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = acc;

endmodule

// File: tb/tb_fan_in_reduce_sched.sv
// Directed bench for fan_in_reduce_sched: an 8-word instance and a 1-word instance on a shared clock/reset.
module tb_fan_in_reduce_sched;
    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_op;
    logic [255:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         busy;
    logic         flush;

    logic         q1_in_valid;
    logic         q1_in_ready;
    logic         q1_in_op;
    logic [31:0]  q1_in_data;
    logic         q1_out_valid;
    logic         q1_out_ready;
    logic [31:0]  q1_out_data;
    logic         q1_busy;
    logic         q1_flush;

    int checks;
    int errors;

    fan_in_reduce_sched #(.WIDTH(32), .QUANTITY(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy), .flush(flush)
    );

    fan_in_reduce_sched #(.WIDTH(32), .QUANTITY(1)) dut_q1 (
        .clk(clk), .rst_n(rst_n), .in_valid(q1_in_valid), .in_ready(q1_in_ready),
        .in_op(q1_in_op), .in_data(q1_in_data), .out_valid(q1_out_valid),
        .out_ready(q1_out_ready), .out_data(q1_out_data), .busy(q1_busy), .flush(q1_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mk(input logic [31:0] fill, input int widx, input logic [31:0] val);
        logic [255:0] d;
        d = {8{fill}};
        d[widx*32 +: 32] = val;
        return d;
    endfunction

    // Offer a job at a negedge; it is accepted at the next posedge (end of cycle C)
    task automatic accept(input string tag, input logic op, input logic [255:0] d);
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_data = '1;
        in_op   = ~op;
    endtask

    // Cycles C+1..C+4 no result, C+5 result, then hand it off
    task automatic run_job(input string tag, input logic op, input logic [255:0] d, input logic [31:0] exp);
        accept(tag, op, d);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("%s_wait%0d_valid", tag, k), 64'(out_valid), 64'd0);
            if (k == 1)
                check({tag, "_busy"}, 64'(busy), 64'd1);
        end
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"}, 64'(out_data), 64'(exp));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_op = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        q1_in_valid = 1'b0; q1_in_op = 1'b0; q1_in_data = '0; q1_out_ready = 1'b0; q1_flush = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_q1_in_ready", 64'(q1_in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // AND with one partially-clear word
        run_job("and", 1'b0, mk(32'hFFFFFFFF, 5, 32'hFFFF0000), 32'hFFFF0000);
        // OR with only the last word set (odd tail uses the identity)
        run_job("or_tail", 1'b1, mk(32'h0, 7, 32'h80000000), 32'h80000000);
        // OR mixing bits from several words
        run_job("or_mix", 1'b1, {32'h1, 32'h0, 32'h0, 32'h100, 32'h0, 32'h0, 32'h0, 32'h10}, 32'h00000111);

        // Backpressure: result held while out_ready is low, no second accept
        accept("hold", 1'b0, mk(32'hFFFFFFFF, 2, 32'h0F0F0F0F));
        repeat (4) @(negedge clk);
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_data = mk(32'h0, k, 32'h0);
            in_op   = k[0];
            check($sformatf("hold%0d_valid", k), 64'(out_valid), 64'd1);
            check($sformatf("hold%0d_data", k), 64'(out_data), 64'h0F0F0F0F);
            check($sformatf("hold%0d_in_ready", k), 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("hold_after_valid", 64'(out_valid), 64'd0);
        check("hold_after_busy", 64'(busy), 64'd0);
        check("hold_after_in_ready", 64'(in_ready), 64'd1);

        // Reset during the second RUN cycle discards the job
        accept("rstmid", 1'b1, mk(32'h0, 1, 32'hDEADBEEF));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_valid", 64'(out_valid), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_in_ready", 64'(in_ready), 64'd1);
        check("rstmid_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_job("post_rst", 1'b1, mk(32'h0, 3, 32'h00000005), 32'h00000005);

        // Flush asserted during the third RUN cycle
        accept("flush", 1'b0, mk(32'hFFFFFFFF, 6, 32'h00FF00FF));
        @(posedge clk);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
`ifdef FAN_IN_SCHED_FLUSH_EN
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("flush%0d_valid", k), 64'(out_valid), 64'd0);
            check($sformatf("flush%0d_busy", k), 64'(busy), 64'd0);
        end
`else
        @(negedge clk);
        check("noflush_c4_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("noflush_c5_valid", 64'(out_valid), 64'd1);
        check("noflush_c5_data", 64'(out_data), 64'h00FF00FF);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
`endif
        @(negedge clk);
        check("flush_end_in_ready", 64'(in_ready), 64'd1);

        // Single-word instance goes straight to DONE
        @(negedge clk);
        q1_in_valid = 1'b1;
        q1_in_op    = 1'b0;
        q1_in_data  = 32'h12345678;
        @(posedge clk);
        #1 q1_in_valid = 1'b0;
        q1_in_data = '0;
        @(negedge clk);
        check("q1_valid", 64'(q1_out_valid), 64'd1);
        check("q1_data", 64'(q1_out_data), 64'h12345678);
        check("q1_in_ready", 64'(q1_in_ready), 64'd0);
        q1_out_ready = 1'b1;
        @(posedge clk);
        #1 q1_out_ready = 1'b0;
        @(negedge clk);
        check("q1_idle", 64'(q1_in_ready), 64'd1);
        check("q1_after_valid", 64'(q1_out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fan_in_reduce_sched.md
FAN_IN_REDUCE_SCHED -- requirements
Module: fan_in_reduce_sched

Interface
REQ-001 Parameter WIDTH, default 32, operand word width in bits.
REQ-002 Parameter QUANTITY, default 8, number of words reduced per job; legal range 1..64.
REQ-003 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port in_valid, input, 1, job request.
REQ-006 Port in_ready, output, 1, block can accept a job.
REQ-007 Port in_op, input, 1, reduction select: 0 = AND, 1 = OR.
REQ-008 Port in_data, input, WIDTH*QUANTITY, operand words; word i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH].
REQ-009 Port out_valid, output, 1, result available.
REQ-010 Port out_ready, input, 1, consumer accepts the result.
REQ-011 Port out_data, output, WIDTH, reduction result.
REQ-012 Port busy, output, 1, high while state is not IDLE.
REQ-013 Port flush, input, 1, job abort; functional only per REQ-030.

Function
REQ-014 The block shall time-share one 3-input WIDTH-bit AND/OR unit; each step combines the accumulator with up to two new words.
REQ-015 The FSM shall have exactly three states: IDLE, RUN and DONE.
REQ-016 in_ready shall equal (state == IDLE); an accept is in_valid && in_ready at a rising edge.
REQ-017 On accept, the block shall latch in_data and in_op, load acc = word 0 and word index = 1.
REQ-018 On accept, the FSM shall go to RUN if QUANTITY > 1 and to DONE if QUANTITY == 1.
REQ-019 Each RUN cycle shall set acc = acc op word[idx] op word[idx+1] and idx += 2.
REQ-020 When idx+1 >= QUANTITY, word[idx+1] shall be replaced by the identity: all-ones for AND, zero for OR.
REQ-021 RUN shall last exactly ceil((QUANTITY-1)/2) cycles, then transition to DONE.
REQ-022 With acceptance at the end of cycle C, out_valid shall first be high in cycle C+1+ceil((QUANTITY-1)/2); for the default QUANTITY this is C+5.
REQ-023 In DONE, out_valid = 1 and out_data = acc; both shall be held stable until out_ready = 1.
REQ-024 DONE with out_ready = 1 shall go to IDLE; a new job cannot be accepted in that same cycle.
REQ-025 in_valid, in_op and in_data shall be ignored outside IDLE; latched operands shall not change mid-job.
REQ-026 out_data shall be driven from acc in every state; it is meaningful only when out_valid = 1.

Reset
REQ-027 While rst_n = 0 the block shall asynchronously force state = IDLE, acc = 0, idx = 0 and the latched op to 0.
REQ-028 While in reset the outputs shall be out_valid = 0, out_data = 0, busy = 0 and in_ready = 1.
REQ-029 Reset asserted mid-RUN or in DONE shall discard the job with no result emitted; the first accept is possible on the first rising edge after deassertion.

Configuration
REQ-030 Macro FAN_IN_SCHED_FLUSH_EN controls the flush feature.
- Defined: flush = 1 at a rising edge in RUN or DONE shall force IDLE, out_valid = 0 next cycle, and drop the result. flush has priority over step, result handoff and accept. flush in IDLE has no effect.
- Undefined: flush shall be ignored and no flush logic synthesized.

Verification (WIDTH=32, QUANTITY=8)
REQ-031 AND job, all words 0xFFFFFFFF except word5 = 0xFFFF0000, accepted at end of cycle C -> out_valid first high in cycle C+5, out_data = 0xFFFF0000.
REQ-032 OR job, words 0..6 = 0, word7 = 0x80000000 (odd tail, identity path) -> out_data = 0x80000000 in cycle C+5.
REQ-033 out_ready held low 3 cycles after out_valid, with in_valid = 1 and changing in_data throughout -> out_valid/out_data stable, in_ready = 0, no second accept; IDLE one cycle after out_ready = 1.
REQ-034 rst_n pulsed low during the 2nd RUN cycle -> out_valid = 0, busy = 0, in_ready = 1 immediately; the following job (OR, word3 = 0x00000005, rest 0) -> 0x00000005.
REQ-035 With FAN_IN_SCHED_FLUSH_EN defined, flush in the 3rd RUN cycle -> IDLE next cycle and no out_valid. Undefined, the same stimulus -> normal result in cycle C+5.
REQ-036 Build with QUANTITY=1, AND, word0 = 0x12345678 -> out_valid in cycle C+1, out_data = 0x12345678, RUN never entered.
